// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding AR/R reads and
// presents one {pc, inst, err} beat at a time on a valid/ready output toward IF/ID.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_err
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_pc;
  logic [31:0] w_pc_d;
  logic [31:0] r_req_addr;
  logic [31:0] w_req_addr_d;
  logic [31:0] r_inst;
  logic [31:0] w_inst_d;
  logic        r_err;
  logic        w_err_d;
  logic        r_kill;
  logic        w_kill_d;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_inst_d  = r_inst;
    w_err_d   = r_err;
    w_kill_d  = r_kill;
    case (r_state)
      StIdle: w_state_d = StReq;
      StReq: begin
        if (arready) begin
          // A read accepted after a redirect still returns data that must be dropped.
          w_state_d = (r_kill || redirect_valid) ? StDrain : StWait;
          w_kill_d  = 1'b0;
          if (redirect_valid) w_pc_d = w_redir_pc;
        end else if (redirect_valid) begin
          w_pc_d   = w_redir_pc;
          w_kill_d = 1'b1;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          w_pc_d    = w_redir_pc;
          w_state_d = rvalid ? StReq : StDrain;
        end else if (rvalid) begin
          w_inst_d  = rdata;
          w_err_d   = (rresp != 2'b00);
          w_state_d = StHold;
        end
      end
      StHold: begin
        // A redirect voids any same-cycle o_ready; downstream flushes on it too.
        if (redirect_valid) begin
          w_pc_d    = w_redir_pc;
          w_state_d = StReq;
        end else if (o_ready) begin
          w_pc_d    = r_req_addr + 32'd4;
          w_state_d = StReq;
        end
      end
      StDrain: begin
        if (redirect_valid) w_pc_d = w_redir_pc;
        if (rvalid) w_state_d = StReq;
      end
      default: w_state_d = StIdle;
    endcase
    w_req_addr_d = ((w_state_d == StReq) && (r_state != StReq)) ? w_pc_d : r_req_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_inst     <= INST_NOP;
      r_err      <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_req_addr <= w_req_addr_d;
      r_inst     <= w_inst_d;
      r_err      <= w_err_d;
      r_kill     <= w_kill_d;
    end
  end

  assign arvalid = (r_state == StReq);
  assign rready  = (r_state == StWait) || (r_state == StDrain);
  assign o_valid = (r_state == StHold);
  assign araddr  = r_req_addr;
  assign o_pc    = r_req_addr;
  assign o_inst  = r_inst;
  assign o_err   = r_err;

endmodule
